simd_register_file: RTL and testbench
=====================================

SIMD_REGISTER_FILE -- requirements
Module: simd_register_file

Interface
REQ-001 Parameters SHALL be:
- THREADS, default 4, lanes per block.
- NUM_REGS, default 16, registers per lane; minimum 4.
- DATA_BITS, default 32, register width.
- RA = clog2(NUM_REGS), register address width.

REQ-002 Ports SHALL be as follows; one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  block active.
- block_id  in  8  current block index.
- core_state  in  3  core pipeline state.
- thread_mask  in  THREADS  active lanes.
- rd_addr, rs_addr, rt_addr  in  RA each  decoded register addresses.
- reg_write_enable  in  1  decoded write enable.
- reg_input_mux  in  2  write source select.
- immediate  in  DATA_BITS  decoded constant.
- alu_out  in  THREADS*DATA_BITS  per-lane ALU result; lane i at bits [i*DATA_BITS +: DATA_BITS].
- wb_valid  in  1  load writeback valid.
- wb_ready  out  1  load writeback ready.
- wb_addr  in  RA  writeback register.
- wb_mask  in  THREADS  writeback lanes.
- wb_data  in  THREADS*DATA_BITS  writeback data.
- rs, rt  out  THREADS*DATA_BITS each  per-lane operands.
- read_valid  out  1  operands valid.
- hazard  out  1  operand read blocked.
- busy_any  out  1  any load outstanding.
- wb_error  out  1  sticky protocol error.

Function
REQ-003 Core states SHALL be REQUEST=3'b011 and UPDATE=3'b110; mux encodings SHALL be ARITHMETIC=2'b00, MEMORY=2'b01, CONSTANT=2'b10, 2'b11=no write.
REQ-004 Read-only registers SHALL be: NUM_REGS-3 = latched block_id (zero-extended); NUM_REGS-2 = THREADS; NUM_REGS-1 = lane index.
REQ-005 block_id SHALL be latched every enabled cycle.
REQ-006 Writes to addresses >= NUM_REGS-3 SHALL be discarded on both paths and SHALL NOT set busy.
REQ-007 The scoreboard SHALL hold one busy bit per register, shared across lanes.
REQ-008 In REQUEST with enable, operand reads SHALL be blocked if busy[rs_addr], busy[rt_addr] or busy[rd_addr] is set.
- Blocked: hazard=1 the same cycle (combinational); rs/rt hold their values; read_valid=0 next cycle.
- Clear: rs/rt for all lanes, including masked lanes, SHALL be registered and read_valid SHALL be 1 for exactly the next cycle.
REQ-009 In UPDATE with enable and reg_write_enable:
- ARITHMETIC: each active lane i SHALL write alu_out lane i to rd.
- CONSTANT: each active lane SHALL write immediate to rd.
- MEMORY: busy[rd] SHALL be set and no data written.
- Inactive lanes SHALL be unchanged.
REQ-010 wb_ready SHALL be 0 when (enable && core_state==UPDATE && reg_write_enable), and 1 otherwise.
REQ-011 On wb_valid&&wb_ready:
- Lanes in wb_mask SHALL be written with wb_data at wb_addr.
- busy[wb_addr] SHALL clear.
- If busy[wb_addr] was 0, wb_error SHALL set and stay set until reset.
REQ-012 A writeback SHALL NOT be bypassed: a REQUEST in the same cycle that a writeback clears busy SHALL still see hazard=1.
REQ-013 busy_any SHALL be the OR of all busy bits, registered.
REQ-014 Writebacks SHALL be accepted regardless of enable.

Reset
REQ-015 While reset=0, all of the following SHALL clear immediately, independent of clk: every writable register in every lane, every busy bit, the latched block_id, rs, rt, read_valid, busy_any and wb_error.
REQ-016 A load outstanding at reset SHALL be forgotten; a later writeback for it SHALL set wb_error.

Structure
REQ-017 A shared package SHALL hold the core-state and mux encodings and the read-only register offsets.
REQ-018 Per-lane storage SHALL be a sub-module, regfile_lane, instantiated THREADS times; the scoreboard, handshake and error logic SHALL live in the top module.

Verification
REQ-019 UPDATE, CONSTANT, rd=5, imm=0x1234, mask=4'b0101 -> REQUEST on rs=5 yields 0x1234 on lanes 0 and 2, 0 on lanes 1 and 3, and read_valid=1 for one cycle.
REQ-020 UPDATE, MEMORY, rd=7 -> REQUEST with rs=7 gives hazard=1 and busy_any=1; wb (addr 7, data 0xA5 on all lanes, mask 4'b1111) -> next REQUEST gives hazard=0 and rs=0xA5 on all lanes.
REQ-021 UPDATE, ARITHMETIC with wb_valid=1 in the same cycle -> wb_ready=0; the writeback is accepted in the following cycle.
REQ-022 Writes to NUM_REGS-1 via ALU and via wb -> reads return the lane index 0..3; busy is never set.
REQ-023 Writeback to a non-busy register 3 -> wb_error=1 and stays 1 until reset; reset asserted mid-load -> busy_any=0 immediately.
REQ-024 block_id=8'h2A while enabled -> a read of NUM_REGS-3 returns 0x2A on all lanes.

Source files
------------

// File: rtl/simd_register_file_pkg.sv
// Shared encodings for the SIMD register file: core pipeline states, write-source
// select values and the offsets of the read-only registers from the top of the file.
package simd_register_file_pkg;

  typedef enum logic [2:0] {
    CS_REQUEST = 3'b011,
    CS_UPDATE  = 3'b110
  } core_state_e;

  typedef enum logic [1:0] {
    MUX_ARITHMETIC = 2'b00,
    MUX_MEMORY     = 2'b01,
    MUX_CONSTANT   = 2'b10,
    MUX_NONE       = 2'b11
  } reg_mux_e;

  // Read-only registers live at NUM_REGS - offset.
  localparam int RO_BLOCK_OFF   = 3;
  localparam int RO_THREADS_OFF = 2;
  localparam int RO_LANE_OFF    = 1;

endpackage

// File: rtl/regfile_lane.sv
// Storage for one SIMD lane: NUM_REGS-3 writable registers plus three read-only
// registers (block id, lane count, lane index), with two combinational read ports.
module regfile_lane
  import simd_register_file_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int DATA_BITS = 32,
  parameter int THREADS   = 4,
  parameter int LANE_ID   = 0,
  parameter int RA        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [RA-1:0]        i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic [RA-1:0]        i_rs_addr,
  input  logic [RA-1:0]        i_rt_addr,
  input  logic [7:0]           i_block_id,
  output logic [DATA_BITS-1:0] o_rs_data,
  output logic [DATA_BITS-1:0] o_rt_data
);

  localparam int NUM_WR = NUM_REGS - RO_BLOCK_OFF;

  logic [DATA_BITS-1:0] r_mem [NUM_WR];

  // NOTE: this storage is flop-based and must clear asynchronously on reset, so it
  // cannot map to a RAM macro; every entry gets an explicit reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_WR; k++) r_mem[k] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  function automatic logic [DATA_BITS-1:0] read_reg(input logic [RA-1:0] addr,
                                                    input logic [7:0]    blk);
    if (int'(addr) == NUM_REGS - RO_BLOCK_OFF)        return DATA_BITS'(blk);
    else if (int'(addr) == NUM_REGS - RO_THREADS_OFF) return DATA_BITS'(THREADS);
    else if (int'(addr) == NUM_REGS - RO_LANE_OFF)    return DATA_BITS'(LANE_ID);
    else if (int'(addr) < NUM_WR)                     return r_mem[addr];
    else                                              return '0;
  endfunction

  assign o_rs_data = read_reg(i_rs_addr, i_block_id);
  assign o_rt_data = read_reg(i_rt_addr, i_block_id);

endmodule

// File: rtl/simd_register_file.sv
// SIMD register file top: per-lane storage, a per-register load scoreboard shared
// across lanes, the load-writeback handshake and a sticky writeback protocol error.
module simd_register_file
  import simd_register_file_pkg::*;
#(
  parameter int THREADS   = 4,
  parameter int NUM_REGS  = 16,
  parameter int DATA_BITS = 32,
  parameter int RA        = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [7:0]                   block_id,
  input  logic [2:0]                   core_state,
  input  logic [THREADS-1:0]           thread_mask,
  input  logic [RA-1:0]                rd_addr,
  input  logic [RA-1:0]                rs_addr,
  input  logic [RA-1:0]                rt_addr,
  input  logic                         reg_write_enable,
  input  logic [1:0]                   reg_input_mux,
  input  logic [DATA_BITS-1:0]         immediate,
  input  logic [THREADS*DATA_BITS-1:0] alu_out,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [RA-1:0]                wb_addr,
  input  logic [THREADS-1:0]           wb_mask,
  input  logic [THREADS*DATA_BITS-1:0] wb_data,
  output logic [THREADS*DATA_BITS-1:0] rs,
  output logic [THREADS*DATA_BITS-1:0] rt,
  output logic                         read_valid,
  output logic                         hazard,
  output logic                         busy_any,
  output logic                         wb_error
);

  localparam logic [RA-1:0] RO_BASE = RA'(NUM_REGS - RO_BLOCK_OFF);

  logic [NUM_REGS-1:0]          r_busy;
  logic [NUM_REGS-1:0]          w_busy_next;
  logic                         r_busy_any;
  logic                         r_wb_error;
  logic                         r_read_valid;
  logic [7:0]                   r_block_id;
  logic [THREADS*DATA_BITS-1:0] r_rs;
  logic [THREADS*DATA_BITS-1:0] r_rt;
  logic [THREADS*DATA_BITS-1:0] w_rs_flat;
  logic [THREADS*DATA_BITS-1:0] w_rt_flat;

  logic w_update_wr;
  logic w_req;
  logic w_wb_fire;
  logic w_rd_writable;
  logic w_wb_writable;
  logic w_data_src;
  logic w_load_issue;
  logic w_read_ok;
  logic [RA-1:0] w_wr_addr;

  assign w_update_wr   = enable && (core_state == CS_UPDATE) && reg_write_enable;
  assign w_req         = enable && (core_state == CS_REQUEST);
  assign wb_ready      = !w_update_wr;
  assign w_wb_fire     = wb_valid && wb_ready;
  assign w_rd_writable = (rd_addr < RO_BASE);
  assign w_wb_writable = (wb_addr < RO_BASE);
  assign w_data_src    = (reg_input_mux == MUX_ARITHMETIC) || (reg_input_mux == MUX_CONSTANT);
  assign w_load_issue  = w_update_wr && (reg_input_mux == MUX_MEMORY) && w_rd_writable;
  // Update writes and writebacks never collide because wb_ready drops for updates.
  assign w_wr_addr     = w_wb_fire ? wb_addr : rd_addr;

  // Hazard looks at the registered scoreboard, so a writeback clearing busy this
  // cycle is deliberately not visible to a same-cycle read.
  assign hazard    = w_req && (r_busy[rs_addr] || r_busy[rt_addr] || r_busy[rd_addr]);
  assign w_read_ok = w_req && !hazard;

  // NOTE: every variable written in always_comb is assigned a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wb_fire)    w_busy_next[wb_addr] = 1'b0;
    if (w_load_issue) w_busy_next[rd_addr] = 1'b1;
  end

  for (genvar i = 0; i < THREADS; i++) begin : g_lane
    logic                 w_we;
    logic [DATA_BITS-1:0] w_wd;

    assign w_we = (w_wb_fire && wb_mask[i] && w_wb_writable) ||
                  (w_update_wr && w_data_src && thread_mask[i] && w_rd_writable);
    assign w_wd = w_wb_fire ? wb_data[i*DATA_BITS +: DATA_BITS]
                : (reg_input_mux == MUX_CONSTANT) ? immediate
                : alu_out[i*DATA_BITS +: DATA_BITS];

    regfile_lane #(
      .NUM_REGS  (NUM_REGS),
      .DATA_BITS (DATA_BITS),
      .THREADS   (THREADS),
      .LANE_ID   (i),
      .RA        (RA)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (w_we),
      .i_wr_addr  (w_wr_addr),
      .i_wr_data  (w_wd),
      .i_rs_addr  (rs_addr),
      .i_rt_addr  (rt_addr),
      .i_block_id (r_block_id),
      .o_rs_data  (w_rs_flat[i*DATA_BITS +: DATA_BITS]),
      .o_rt_data  (w_rt_flat[i*DATA_BITS +: DATA_BITS])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= '0;
      r_busy_any   <= 1'b0;
      r_wb_error   <= 1'b0;
      r_read_valid <= 1'b0;
      r_block_id   <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
    end else begin
      r_busy       <= w_busy_next;
      r_busy_any   <= |w_busy_next;
      r_read_valid <= w_read_ok;
      if (w_wb_fire && !r_busy[wb_addr]) r_wb_error <= 1'b1;
      if (enable) r_block_id <= block_id;
      if (w_read_ok) begin
        r_rs <= w_rs_flat;
        r_rt <= w_rt_flat;
      end
    end
  end

  assign rs         = r_rs;
  assign rt         = r_rt;
  assign read_valid = r_read_valid;
  assign busy_any   = r_busy_any;
  assign wb_error   = r_wb_error;

endmodule

// File: tb/tb_simd_register_file.sv
// Self-checking bench for simd_register_file: directed scenarios followed by random
// traffic, all compared against an array-based behavioural model.
module tb_simd_register_file;

  localparam int T = 4;
  localparam int N = 16;
  localparam int D = 32;
  localparam int A = 4;
  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;
  localparam logic [2:0] IDL = 3'b000;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [7:0]     block_id;
  logic [2:0]     core_state;
  logic [T-1:0]   thread_mask;
  logic [A-1:0]   rd_addr, rs_addr, rt_addr;
  logic           reg_write_enable;
  logic [1:0]     reg_input_mux;
  logic [D-1:0]   immediate;
  logic [T*D-1:0] alu_out;
  logic           wb_valid;
  logic           wb_ready;
  logic [A-1:0]   wb_addr;
  logic [T-1:0]   wb_mask;
  logic [T*D-1:0] wb_data;
  logic [T*D-1:0] rs, rt;
  logic           read_valid, hazard, busy_any, wb_error;

  simd_register_file dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .core_state(core_state), .thread_mask(thread_mask), .rd_addr(rd_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .reg_write_enable(reg_write_enable),
    .reg_input_mux(reg_input_mux), .immediate(immediate), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_mask(wb_mask),
    .wb_data(wb_data), .rs(rs), .rt(rt), .read_valid(read_valid), .hazard(hazard),
    .busy_any(busy_any), .wb_error(wb_error)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain arrays of register values and busy flags.
  logic [D-1:0]   m_reg [T][N];
  bit             m_busy [N];
  logic [7:0]     m_blk;
  bit             m_err;
  bit             m_rv;
  logic [T*D-1:0] m_rs, m_rt;

  int    n_vec = 0;
  int    n_err = 0;
  string g_tag = "init";

  task automatic check(input string tag, input logic [T*D-1:0] got, input logic [T*D-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [D-1:0] model_read(input int lane, input int addr);
    if (addr == N - 3) return {24'h0, m_blk};
    if (addr == N - 2) return D'(T);
    if (addr == N - 1) return D'(lane);
    return m_reg[lane][addr];
  endfunction

  function automatic bit model_busy_any();
    bit b = 0;
    for (int r = 0; r < N; r++) b |= m_busy[r];
    return b;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < T; l++) for (int r = 0; r < N; r++) m_reg[l][r] = '0;
    for (int r = 0; r < N; r++) m_busy[r] = 0;
    m_blk = '0; m_err = 0; m_rv = 0; m_rs = '0; m_rt = '0;
  endtask

  task automatic set_idle();
    enable = 1'b1; core_state = IDL; thread_mask = '1; block_id = '0;
    rd_addr = '0; rs_addr = '0; rt_addr = '0; reg_write_enable = 1'b0;
    reg_input_mux = 2'b11; immediate = '0; alu_out = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_mask = '0; wb_data = '0;
  endtask

  task automatic check_outputs();
    check({g_tag, ":rs"}, rs, m_rs);
    check({g_tag, ":rt"}, rt, m_rt);
    check({g_tag, ":read_valid"}, T*D'(read_valid), T*D'(m_rv));
    check({g_tag, ":busy_any"}, T*D'(busy_any), T*D'(model_busy_any()));
    check({g_tag, ":wb_error"}, T*D'(wb_error), T*D'(m_err));
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit exp_ready, exp_haz, fire, read_ok;
    int rd, wa;
    #1;
    exp_ready = !(enable && core_state == UPD && reg_write_enable);
    exp_haz   = enable && core_state == REQ &&
                (m_busy[rs_addr] || m_busy[rt_addr] || m_busy[rd_addr]);
    check({g_tag, ":wb_ready"}, T*D'(wb_ready), T*D'(exp_ready));
    check({g_tag, ":hazard"}, T*D'(hazard), T*D'(exp_haz));
    @(posedge clk);
    read_ok = enable && core_state == REQ && !exp_haz;
    if (read_ok)
      for (int l = 0; l < T; l++) begin
        m_rs[l*D +: D] = model_read(l, int'(rs_addr));
        m_rt[l*D +: D] = model_read(l, int'(rt_addr));
      end
    m_rv = read_ok;
    rd = int'(rd_addr);
    if (!exp_ready && rd < N - 3) begin
      for (int l = 0; l < T; l++)
        if (thread_mask[l]) begin
          if (reg_input_mux == 2'b00) m_reg[l][rd] = alu_out[l*D +: D];
          if (reg_input_mux == 2'b10) m_reg[l][rd] = immediate;
        end
      if (reg_input_mux == 2'b01) m_busy[rd] = 1;
    end
    fire = wb_valid && exp_ready;
    if (fire) begin
      wa = int'(wb_addr);
      if (!m_busy[wa]) m_err = 1;
      m_busy[wa] = 0;
      if (wa < N - 3)
        for (int l = 0; l < T; l++) if (wb_mask[l]) m_reg[l][wa] = wb_data[l*D +: D];
    end
    if (enable) m_blk = block_id;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_clear();
    g_tag = "reset";
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    set_idle();
    model_clear();
    reset = 1'b0;
    #12;
    g_tag = "por";
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Constant write to masked lanes, then read it back.
    g_tag = "const_wr";
    set_idle(); core_state = UPD; reg_write_enable = 1; reg_input_mux = 2'b10;
    rd_addr = 5; immediate = 32'h1234; thread_mask = 4'b0101;
    cycle();
    g_tag = "const_rd";
    set_idle(); core_state = REQ; rs_addr = 5; rt_addr = 5;
    cycle();
    check("const_rd_val", rs, {32'h0, 32'h1234, 32'h0, 32'h1234});
    check("const_rd_valid", T*D'(read_valid), T*D'(1));
    g_tag = "const_rv_drop";
    set_idle();
    cycle();
    check("const_rv_one_cycle", T*D'(read_valid), T*D'(0));

    // Load to r7: hazard until writeback.
    g_tag = "load_issue";
    set_idle(); core_state = UPD; reg_write_enable = 1; reg_input_mux = 2'b01; rd_addr = 7;
    cycle();
    g_tag = "load_hazard";
    set_idle(); core_state = REQ; rs_addr = 7;
    #1;
    check("load_hazard_hz", T*D'(hazard), T*D'(1));
    check("load_hazard_busy", T*D'(busy_any), T*D'(1));
    cycle();
    g_tag = "load_wb";
    set_idle(); wb_valid = 1; wb_addr = 7; wb_mask = 4'b1111; wb_data = {4{32'hA5}};
    cycle();
    g_tag = "load_read";
    set_idle(); core_state = REQ; rs_addr = 7;
    cycle();
    check("load_read_val", rs, {4{32'hA5}});

    // Writeback stalled behind an arithmetic update.
    g_tag = "stall_issue";
    set_idle(); core_state = UPD; reg_write_enable = 1; reg_input_mux = 2'b01; rd_addr = 8;
    cycle();
    g_tag = "stall_upd";
    set_idle(); core_state = UPD; reg_write_enable = 1; reg_input_mux = 2'b00; rd_addr = 2;
    alu_out = {32'h33, 32'h22, 32'h11, 32'h00};
    wb_valid = 1; wb_addr = 8; wb_mask = 4'b1111; wb_data = {4{32'h77}};
    #1;
    check("stall_ready_low", T*D'(wb_ready), T*D'(0));
    cycle();
    check("stall_still_busy", T*D'(busy_any), T*D'(1));
    g_tag = "stall_accept";
    core_state = IDL; reg_write_enable = 0;
    cycle();
    check("stall_accepted", T*D'(busy_any), T*D'(0));
    check("stall_no_err", T*D'(wb_error), T*D'(0));

    // Writes to read-only registers are discarded on both paths.
    g_tag = "ro_alu";
    set_idle(); core_state = UPD; reg_write_enable = 1; reg_input_mux = 2'b00; rd_addr = 15;
    alu_out = {4{32'hDEAD}};
    cycle();
    g_tag = "ro_wb";
    set_idle(); wb_valid = 1; wb_addr = 15; wb_mask = 4'b1111; wb_data = {4{32'hBEEF}};
    cycle();
    g_tag = "ro_read";
    set_idle(); core_state = REQ; rs_addr = 15; rt_addr = 14;
    cycle();
    check("ro_lane_idx", rs, {32'd3, 32'd2, 32'd1, 32'd0});
    check("ro_threads", rt, {4{32'd4}});
    check("ro_never_busy", T*D'(busy_any), T*D'(0));

    // Sticky error, then async reset in the middle of a load.
    pulse_reset();
    g_tag = "err_wb";
    set_idle(); wb_valid = 1; wb_addr = 3; wb_mask = 4'b1111; wb_data = {4{32'h5}};
    cycle();
    check("err_set", T*D'(wb_error), T*D'(1));
    g_tag = "err_hold";
    set_idle();
    repeat (3) cycle();
    check("err_sticky", T*D'(wb_error), T*D'(1));
    g_tag = "rst_load";
    set_idle(); core_state = UPD; reg_write_enable = 1; reg_input_mux = 2'b01; rd_addr = 7;
    cycle();
    set_idle();
    #2;
    reset = 1'b0;
    #1;
    check("rst_busy_any", T*D'(busy_any), T*D'(0));
    check("rst_err", T*D'(wb_error), T*D'(0));
    check("rst_rs", rs, '0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    g_tag = "rst_stale_wb";
    set_idle(); wb_valid = 1; wb_addr = 7; wb_mask = 4'b1111;
    cycle();
    check("rst_stale_err", T*D'(wb_error), T*D'(1));

    // Block id latching.
    g_tag = "blk_latch";
    set_idle(); block_id = 8'h2A;
    cycle();
    g_tag = "blk_read";
    core_state = REQ; rs_addr = 13; rt_addr = 5;
    cycle();
    check("blk_val", rs, {4{32'h2A}});

    // Random traffic.
    pulse_reset();
    g_tag = "rand";
    for (int n = 0; n < 600; n++) begin
      int bl [$];
      set_idle();
      enable           = ($urandom_range(0, 7) != 0);
      block_id         = 8'($urandom);
      thread_mask      = 4'($urandom);
      rd_addr          = 4'($urandom);
      rs_addr          = 4'($urandom);
      rt_addr          = 4'($urandom);
      reg_write_enable = ($urandom_range(0, 3) != 0);
      reg_input_mux    = 2'($urandom);
      immediate        = $urandom;
      alu_out          = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
        0: core_state = REQ;
        1: core_state = UPD;
        default: core_state = 3'($urandom);
      endcase
      wb_valid = ($urandom_range(0, 2) == 0);
      for (int r = 0; r < N; r++) if (m_busy[r]) bl.push_back(r);
      if (bl.size() > 0 && $urandom_range(0, 3) != 0)
        wb_addr = A'(bl[$urandom_range(0, bl.size() - 1)]);
      else
        wb_addr = 4'($urandom);
      wb_mask = 4'($urandom);
      wb_data = {$urandom, $urandom, $urandom, $urandom};
      if (n == 300) pulse_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
